mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 40 ++++
 rtl/mem_arbiter_rd_return.sv | 55 +++++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port cache-line memory arbiter.
// Holds the FSM state encoding, owner encoding and burst address helpers.
package mem_arb_pkg;

  localparam int BEATS  = 4;
  localparam int BEAT_W = 2;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int LINE_W = ADDR_W - 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_e;

  // Word address of one beat inside a line: bit 0 is the byte lane, always 0.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [LINE_W-1:0] line,
                                                  input logic [BEAT_W-1:0] b);
    return {line, b, 1'b0};
  endfunction

  // Round robin: on a tie the requester that was not granted last wins.
  function automatic owner_e pick_owner(input logic ic_req, input logic dc_req,
                                        input owner_e last);
    if (ic_req && dc_req) begin
      return (last == OWN_IC) ? OWN_DC : OWN_IC;
    end else if (dc_req) begin
      return OWN_DC;
    end
    return OWN_IC;
  endfunction

endpackage

// File: rtl/mem_arbiter_rd_return.sv
// Read-return tracker: a MEM_LAT-deep shift register carrying valid, owner and
// beat index so each returned word can be steered to the requester that issued it.
module rd_return_pipe
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  owner_e            in_owner,
  input  logic [BEAT_W-1:0] in_beat,
  output logic              out_vld,
  output owner_e            out_owner,
  output logic [BEAT_W-1:0] out_beat
);

  logic [MEM_LAT-1:0] vld_d, vld_q;
  owner_e             own_d  [MEM_LAT];
  owner_e             own_q  [MEM_LAT];
  logic [BEAT_W-1:0]  beat_d [MEM_LAT];
  logic [BEAT_W-1:0]  beat_q [MEM_LAT];

  always_comb begin
    vld_d     = '0;
    vld_d[0]  = in_vld;
    own_d[0]  = in_owner;
    beat_d[0] = in_beat;
    for (int i = 1; i < MEM_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      own_d[i]  = own_q[i-1];
      beat_d[i] = beat_q[i-1];
    end
  end

  // Reset flushes everything so returns from an abandoned burst never surface.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      for (int i = 0; i < MEM_LAT; i++) begin
        own_q[i]  <= OWN_IC;
        beat_q[i] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      own_q  <= own_d;
      beat_q <= beat_d;
    end
  end

  assign out_vld   = vld_q[MEM_LAT-1];
  assign out_owner = own_q[MEM_LAT-1];
  assign out_beat  = beat_q[MEM_LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache and D-cache line bursts onto a single memory port,
// issues BEATS word accesses per burst and routes read returns to the owner.
module mem_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int BEATS   = mem_arb_pkg::BEATS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ic_req,
  input  logic        dc_req,
  input  logic        ic_wr,
  input  logic        dc_wr,
  input  logic [15:0] ic_addr,
  input  logic [15:0] dc_addr,
  input  logic [15:0] ic_wdata,
  input  logic [15:0] dc_wdata,
  output logic        ic_gnt,
  output logic        dc_gnt,
  output logic [1:0]  beat,
  output logic [15:0] rdata,
  output logic        ic_rvalid,
  output logic        dc_rvalid,
  output logic [1:0]  rbeat,
  output logic        ic_done,
  output logic        dc_done,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic        mem_stall,
  input  logic [15:0] mem_rdata
);
  import mem_arb_pkg::*;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  arb_state_e        state_d, state_q;
  logic [BEAT_W-1:0] beat_d, beat_q;
  owner_e            owner_d, owner_q;
  owner_e            last_d, last_q;
  logic              wr_d, wr_q;
  logic [LINE_W-1:0] line_d, line_q;

  owner_e            sel_own;
  logic              issuing;
  logic              in_burst;
  logic              ret_vld;
  owner_e            ret_owner;
  logic [BEAT_W-1:0] ret_beat;
  logic              unused_addr_lsbs;

  assign unused_addr_lsbs = ^{ic_addr[2:0], dc_addr[2:0]};

  assign sel_own = pick_owner(ic_req, dc_req, last_q);

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    owner_d = owner_q;
    last_d  = last_q;
    wr_d    = wr_q;
    line_d  = line_q;
    case (state_q)
      IDLE: begin
        if (ic_req || dc_req) begin
          owner_d = sel_own;
          wr_d    = (sel_own == OWN_DC) ? dc_wr : ic_wr;
          line_d  = (sel_own == OWN_DC) ? dc_addr[ADDR_W-1:3] : ic_addr[ADDR_W-1:3];
          beat_d  = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // A stalled beat keeps address, data and strobes frozen.
        if (!mem_stall) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == LAST_BEAT) begin
            state_d = wr_q ? DONE : DRAIN;
          end
        end
      end
      DRAIN: begin
        if (ret_vld && (ret_beat == LAST_BEAT)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      owner_q <= OWN_IC;
      last_q  <= OWN_IC;
      wr_q    <= 1'b0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      line_q  <= line_d;
    end
  end

  // Issue stage: memory request decoded from the registered burst context.
  assign issuing  = (state_q == ISSUE);
  assign in_burst = (state_q == ISSUE) || (state_q == DRAIN);

  assign ic_gnt    = in_burst && (owner_q == OWN_IC);
  assign dc_gnt    = in_burst && (owner_q == OWN_DC);
  assign beat      = beat_q;
  assign mem_rd    = issuing && !wr_q;
  assign mem_wr    = issuing && wr_q;
  assign mem_addr  = issuing ? beat_addr(line_q, beat_q) : '0;
  assign mem_wdata = mem_wr ? ((owner_q == OWN_DC) ? dc_wdata : ic_wdata) : '0;

  rd_return_pipe #(
    .MEM_LAT (MEM_LAT)
  ) u_rd_return (
    .clk       (clk),
    .rst       (rst),
    .in_vld    (mem_rd && !mem_stall),
    .in_owner  (owner_q),
    .in_beat   (beat_q),
    .out_vld   (ret_vld),
    .out_owner (ret_owner),
    .out_beat  (ret_beat)
  );

  // Return stage: steer the word arriving this cycle to the requester that issued it.
  assign ic_rvalid = ret_vld && (ret_owner == OWN_IC);
  assign dc_rvalid = ret_vld && (ret_owner == OWN_DC);
  assign rbeat     = ret_vld ? ret_beat : '0;
  assign rdata     = ret_vld ? mem_rdata : '0;

  assign ic_done = (state_q == DONE) && (owner_q == OWN_IC);
  assign dc_done = (state_q == DONE) && (owner_q == OWN_DC);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: tests push expected issues/returns/done
// pulses, and the scoreboard pops and compares them as the DUT produces them.
module tb_mem_arbiter;

  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ic_req, dc_req, ic_wr, dc_wr;
  logic [15:0] ic_addr, dc_addr, ic_wdata, dc_wdata;
  logic        ic_gnt, dc_gnt;
  logic [1:0]  beat, rbeat;
  logic [15:0] rdata;
  logic        ic_rvalid, dc_rvalid, ic_done, dc_done;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_rd, mem_wr;
  logic        mem_stall;
  logic [15:0] mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(MEM_LAT), .BEATS(4)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .dc_req(dc_req), .ic_wr(ic_wr), .dc_wr(dc_wr),
    .ic_addr(ic_addr), .dc_addr(dc_addr), .ic_wdata(ic_wdata), .dc_wdata(dc_wdata),
    .ic_gnt(ic_gnt), .dc_gnt(dc_gnt), .beat(beat), .rdata(rdata),
    .ic_rvalid(ic_rvalid), .dc_rvalid(dc_rvalid), .rbeat(rbeat),
    .ic_done(ic_done), .dc_done(dc_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_stall(mem_stall), .mem_rdata(mem_rdata)
  );

  // Requesters supply the write word for whatever beat is being issued.
  assign ic_wdata = 16'hC000 | {14'd0, beat};
  assign dc_wdata = 16'hD000 | {14'd0, beat};

  // Memory model: returns addr ^ A5A5 exactly MEM_LAT cycles after an accepted read.
  logic        mp_vld  [MEM_LAT];
  logic [15:0] mp_addr [MEM_LAT];
  always @(posedge clk) begin
    mp_vld[0]  <= mem_rd && !mem_stall;
    mp_addr[0] <= mem_addr;
    for (int i = 1; i < MEM_LAT; i++) begin
      mp_vld[i]  <= mp_vld[i-1];
      mp_addr[i] <= mp_addr[i-1];
    end
  end
  assign mem_rdata = (mp_vld[MEM_LAT-1] === 1'b1) ? (mp_addr[MEM_LAT-1] ^ 16'hA5A5) : 16'h0000;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit dc; bit wr; logic [15:0] addr; logic [15:0] wdata; } iss_t;
  typedef struct { bit dc; logic [1:0] beat; logic [15:0] data; } ret_t;
  typedef struct { bit dc; bit wr; } done_t;

  iss_t  iss_q[$];
  ret_t  ret_q[$];
  done_t done_q[$];
  int    acc_q[$];

  int checks = 0;
  int failures = 0;
  int first_acc, last_acc, last_ret, hold_cnt, stall_left;
  bit stall_b1, drop_b1;

  task automatic push_burst(input bit dc, input bit wr, input logic [15:0] base);
    iss_t e; ret_t r; done_t d; logic [15:0] a;
    for (int b = 0; b < 4; b++) begin
      a       = {base[15:3], 2'(b), 1'b0};
      e.dc    = dc;
      e.wr    = wr;
      e.addr  = a;
      e.wdata = (dc ? 16'hD000 : 16'hC000) | 16'(b);
      iss_q.push_back(e);
      if (!wr) begin
        r.dc   = dc;
        r.beat = 2'(b);
        r.data = a ^ 16'hA5A5;
        ret_q.push_back(r);
      end
    end
    d.dc = dc;
    d.wr = wr;
    done_q.push_back(d);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    ic_req = 0; dc_req = 0; ic_wr = 0; dc_wr = 0;
    ic_addr = 16'h0; dc_addr = 16'h0; mem_stall = 0;
    iss_q.delete(); ret_q.delete(); done_q.delete(); acc_q.delete();
    first_acc = -1; last_acc = 0; last_ret = 0; hold_cnt = 0; stall_left = 0;
    stall_b1 = 0; drop_b1 = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_scoreboard(input int budget);
    iss_t e; ret_t r; done_t d; int a; int n; bit fin;
    n = 0; fin = 0;
    while (!fin && n < budget) begin
      @(negedge clk);
      n++;
      mem_stall = 1'b0;
      if (stall_b1 && mem_wr && beat == 2'd1 && stall_left > 0) begin
        mem_stall = 1'b1;
        stall_left--;
      end
      if (mem_wr && mem_addr == 16'h0042) hold_cnt++;
      checks++;
      if (ic_gnt && dc_gnt) begin
        failures++;
        $display("FAIL gnt_excl cyc=%0d ic_gnt=%b dc_gnt=%b required at most one", cyc, ic_gnt, dc_gnt);
      end
      if (mem_rd || mem_wr) begin
        checks++;
        if (iss_q.size() == 0) begin
          failures++;
          $display("FAIL issue_extra cyc=%0d mem_addr=%h required no request", cyc, mem_addr);
        end else begin
          e = iss_q[0];
          if (mem_addr !== e.addr || {mem_rd, mem_wr} !== (e.wr ? 2'b01 : 2'b10)) begin
            failures++;
            $display("FAIL issue_addr cyc=%0d got addr=%h rd=%b wr=%b required addr=%h wr=%b",
                     cyc, mem_addr, mem_rd, mem_wr, e.addr, e.wr);
          end
          checks++;
          if ({dc_gnt, ic_gnt} !== (e.dc ? 2'b10 : 2'b01)) begin
            failures++;
            $display("FAIL issue_gnt cyc=%0d got dc_gnt=%b ic_gnt=%b required dc=%b", cyc, dc_gnt, ic_gnt, e.dc);
          end
          if (e.wr) begin
            checks++;
            if (mem_wdata !== e.wdata) begin
              failures++;
              $display("FAIL issue_wdata cyc=%0d got %h required %h", cyc, mem_wdata, e.wdata);
            end
          end
          if (!mem_stall) begin
            e = iss_q.pop_front();
            if (!e.wr) acc_q.push_back(cyc);
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
            if (drop_b1 && e.dc && e.addr[2:1] == 2'd1) begin
              dc_req = 0; dc_addr = 16'hFFF8; dc_wr = 1; drop_b1 = 0;
            end
          end
        end
      end
      if (ic_rvalid || dc_rvalid) begin
        checks++;
        if (ret_q.size() == 0 || acc_q.size() == 0) begin
          failures++;
          $display("FAIL rvalid_extra cyc=%0d rbeat=%0d required no return", cyc, rbeat);
        end else begin
          r = ret_q.pop_front();
          a = acc_q.pop_front();
          if ({dc_rvalid, ic_rvalid} !== (r.dc ? 2'b10 : 2'b01) || rbeat !== r.beat || rdata !== r.data) begin
            failures++;
            $display("FAIL ret_data cyc=%0d got dc=%b ic=%b beat=%0d data=%h required dc=%b beat=%0d data=%h",
                     cyc, dc_rvalid, ic_rvalid, rbeat, rdata, r.dc, r.beat, r.data);
          end
          checks++;
          if (cyc != a + MEM_LAT) begin
            failures++;
            $display("FAIL ret_latency got cyc=%0d required %0d", cyc, a + MEM_LAT);
          end
          last_ret = cyc;
        end
      end
      if (ic_done || dc_done) begin
        checks++;
        if (done_q.size() == 0) begin
          failures++;
          $display("FAIL done_extra cyc=%0d ic_done=%b dc_done=%b required none", cyc, ic_done, dc_done);
        end else begin
          d = done_q.pop_front();
          if ({dc_done, ic_done} !== (d.dc ? 2'b10 : 2'b01)) begin
            failures++;
            $display("FAIL done_owner got dc=%b ic=%b required dc=%b", dc_done, ic_done, d.dc);
          end
          checks++;
          if (cyc != (d.wr ? last_acc : last_ret) + 1) begin
            failures++;
            $display("FAIL done_timing got cyc=%0d required %0d", cyc, (d.wr ? last_acc : last_ret) + 1);
          end
          if (d.dc) dc_req = 0; else ic_req = 0;
          if (done_q.size() == 0) fin = 1;
        end
      end
    end
    checks++;
    if (!fin || iss_q.size() != 0 || ret_q.size() != 0) begin
      failures++;
      $display("FAIL sb_incomplete fin=%b issues_left=%0d returns_left=%0d required all consumed",
               fin, iss_q.size(), ret_q.size());
    end
    @(negedge clk);
    checks++;
    if (ic_done || dc_done) begin
      failures++;
      $display("FAIL done_pulse ic_done=%b dc_done=%b required 0 after one cycle", ic_done, dc_done);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    rst = 1'b0;
    #1;
    checks++;
    if ({ic_gnt, dc_gnt, mem_rd, mem_wr, ic_rvalid, dc_rvalid, ic_done, dc_done} !== 8'h00) begin
      failures++;
      $display("FAIL reset_ctrl got %b required 00000000",
               {ic_gnt, dc_gnt, mem_rd, mem_wr, ic_rvalid, dc_rvalid, ic_done, dc_done});
    end
    checks++;
    if (mem_addr !== 16'h0 || mem_wdata !== 16'h0 || rdata !== 16'h0) begin
      failures++;
      $display("FAIL reset_data got addr=%h wdata=%h rdata=%h required 0", mem_addr, mem_wdata, rdata);
    end
    checks++;
    if (beat !== 2'd0 || rbeat !== 2'd0) begin
      failures++;
      $display("FAIL reset_beat got beat=%0d rbeat=%0d required 0", beat, rbeat);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ic_gnt || dc_gnt || mem_rd || mem_wr) begin
        failures++;
        $display("FAIL idle_quiet got gnt=%b%b rd=%b wr=%b required all 0", ic_gnt, dc_gnt, mem_rd, mem_wr);
      end
    end
  endtask

  task automatic test_read_burst();
    apply_reset();
    push_burst(1'b1, 1'b0, 16'h1238);
    dc_wr = 0; dc_addr = 16'h1238; dc_req = 1;
    run_scoreboard(40);
    checks++;
    if (last_acc - first_acc != 3) begin
      failures++;
      $display("FAIL read_consecutive got span=%0d required 3", last_acc - first_acc);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    push_burst(1'b1, 1'b0, 16'h1238);
    push_burst(1'b0, 1'b0, 16'h2000);
    dc_addr = 16'h1238; ic_addr = 16'h2000;
    dc_req = 1; ic_req = 1;
    run_scoreboard(60);
    // I-cache was granted last, so a fresh tie goes to the D-cache.
    push_burst(1'b1, 1'b0, 16'h3330);
    push_burst(1'b0, 1'b0, 16'h4448);
    dc_addr = 16'h3330; ic_addr = 16'h4448;
    dc_req = 1; ic_req = 1;
    run_scoreboard(60);
  endtask

  task automatic test_write_stall();
    apply_reset();
    push_burst(1'b0, 1'b1, 16'h0040);
    stall_b1 = 1; stall_left = 2; hold_cnt = 0;
    ic_wr = 1; ic_addr = 16'h0040; ic_req = 1;
    run_scoreboard(40);
    checks++;
    if (hold_cnt != 3) begin
      failures++;
      $display("FAIL stall_hold got %0d cycles of 0042 required 3", hold_cnt);
    end
    stall_b1 = 0; ic_wr = 0;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    push_burst(1'b1, 1'b1, 16'h7770);
    push_burst(1'b0, 1'b0, 16'h8888);
    dc_wr = 1; dc_addr = 16'h7770; ic_addr = 16'h8888;
    dc_req = 1; ic_req = 1;
    run_scoreboard(60);
    dc_wr = 0;
  endtask

  task automatic test_req_drop();
    apply_reset();
    push_burst(1'b1, 1'b0, 16'h3450);
    drop_b1 = 1;
    dc_wr = 0; dc_addr = 16'h3450; dc_req = 1;
    run_scoreboard(40);
    dc_wr = 0;
  endtask

  task automatic test_reset_mid_burst();
    bit found;
    apply_reset();
    dc_wr = 0; dc_addr = 16'h5550; dc_req = 1;
    found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (mem_rd && beat == 2'd2) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL midrst_reach got no beat 2 issue required one within 20 cycles");
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({ic_gnt, dc_gnt, mem_rd, mem_wr, ic_rvalid, dc_rvalid, ic_done, dc_done} !== 8'h00 ||
        mem_addr !== 16'h0 || rdata !== 16'h0 || beat !== 2'd0) begin
      failures++;
      $display("FAIL midrst_zero got ctrl=%b addr=%h rdata=%h beat=%0d required all 0",
               {ic_gnt, dc_gnt, mem_rd, mem_wr, ic_rvalid, dc_rvalid, ic_done, dc_done},
               mem_addr, rdata, beat);
    end
    @(negedge clk);
    rst = 1'b1; dc_req = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (ic_rvalid || dc_rvalid || ic_done || dc_done || ic_gnt || dc_gnt || mem_rd || mem_wr) begin
        failures++;
        $display("FAIL midrst_quiet cyc=%0d rvalid=%b%b done=%b%b gnt=%b%b required all 0",
                 cyc, ic_rvalid, dc_rvalid, ic_done, dc_done, ic_gnt, dc_gnt);
      end
    end
    push_burst(1'b1, 1'b0, 16'h6668);
    dc_addr = 16'h6668; dc_req = 1;
    run_scoreboard(40);
  endtask

  initial begin
    test_reset();
    test_read_burst();
    test_round_robin();
    test_write_stall();
    test_back_to_back();
    test_req_drop();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
